// File: rtl/key_event_pkg.sv
// +--------------------------------------------------------------------+
// | key_event_pkg: shared constants, FSM state type and helpers        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package key_event_pkg;

  localparam int KEY_MIN        = 1;
  localparam int KEY_MAX        = 11;
  localparam int KEY_CODE_W     = 4;
  localparam int EVT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_key_code(input logic [KEY_CODE_W-1:0] code);
    return (code >= KEY_CODE_W'(KEY_MIN)) && (code <= KEY_CODE_W'(KEY_MAX));
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_fifo.sv
// +--------------------------------------------------------------------+
// | key_event_fifo: synchronous FIFO; push to full is allowed only     |
// | together with a pop. Revision: 1.0                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = EVT_FIFO_DEPTH,
  parameter int WIDTH = KEY_CODE_W
) (
  input  logic             clk_1mhz,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event_ctrl.sv
// +--------------------------------------------------------------------+
// | key_event_ctrl: key debounce FSM feeding a key-event queue.        |
// | Define KEY_REPEAT_EN to enable auto-repeat while held. Rev: 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic                  clk_1mhz,
  input  logic                  rst,
  input  logic                  button_pressed,
  input  logic [KEY_CODE_W-1:0] button_value,
  input  logic                  enable,
  output logic                  evt_valid,
  output logic [KEY_CODE_W-1:0] evt_code,
  input  logic                  evt_ready,
  output logic                  evt_overflow,
  output logic                  busy
);

  localparam int CNT_MAX = max_of3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  key_state_e            state_q, state_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  pressed, same_key, push, pop, fifo_full, fifo_empty;
  logic [KEY_CODE_W-1:0] fifo_dout;
`ifdef KEY_REPEAT_EN
  logic [CNT_W-1:0]      rep_q, rep_d;
  logic                  rep_armed_q, rep_armed_d;
`endif

  assign pressed  = button_pressed && is_key_code(button_value);
  assign same_key = pressed && (button_value == cand_q);
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign pop      = evt_valid && evt_ready;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef KEY_REPEAT_EN
      rep_d       = '0;
      rep_armed_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The accepting sample itself is the first of the stable run.
          if (pressed) begin
            cand_d  = button_value;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
            if (DEBOUNCE_CYCLES <= 1) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LIM) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (same_key) begin
`ifdef KEY_REPEAT_EN
            if (rep_q == (rep_armed_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY))) begin
              push        = 1'b1;
              rep_d       = CNT_W'(1);
              rep_armed_d = 1'b1;
            end else if (rep_q != CNT_SAT) begin
              rep_d = rep_q + CNT_W'(1);
            end
`endif
          end else begin
            cnt_d   = pressed ? '0 : CNT_W'(1);
            state_d = (!pressed && DEBOUNCE_CYCLES <= 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (pressed) begin
            cnt_d = '0;
          end else if (cnt_inc >= DEB_LIM) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
`ifdef KEY_REPEAT_EN
      if (state_d != ST_HELD) begin
        rep_d       = '0;
        rep_armed_d = 1'b0;
      end
`endif
    end
    busy_d = (state_d != ST_IDLE);
    ovf_d  = ovf_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
`ifdef KEY_REPEAT_EN
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
`endif
    end
  end

  key_event_fifo #(
    .DEPTH (EVT_FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk_1mhz (clk_1mhz),
    .rst      (rst),
    .push     (push),
    .din      (cand_q),
    .pop      (pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid    = !fifo_empty;
  assign evt_code     = fifo_empty ? '0 : fifo_dout;
  assign evt_overflow = ovf_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_key_event_ctrl: vector table, directed corner cases and random  |
// | stimulus against a behavioural model. Revision: 1.0                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_key_event_ctrl;

  localparam int DEB = 4;
  localparam int DELAY = 10;
  localparam int PERIOD = 5;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_DEB = 1, P_HELD = 2, P_REL = 3;

  logic       clk_1mhz = 1'b0;
  logic       rst = 1'b1;
  logic       button_pressed = 1'b0;
  logic [3:0] button_value = 4'd0;
  logic       enable = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_overflow, busy;
  logic [3:0] evt_code;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int         m_phase, m_run, m_held;
  logic [3:0] m_cand;
  logic [3:0] m_q[$];
  bit         m_ovf;

  key_event_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) dut (
    .clk_1mhz       (clk_1mhz),
    .rst            (rst),
    .button_pressed (button_pressed),
    .button_value   (button_value),
    .enable         (enable),
    .evt_valid      (evt_valid),
    .evt_code       (evt_code),
    .evt_ready      (evt_ready),
    .evt_overflow   (evt_overflow),
    .busy           (busy)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit bp, input logic [3:0] v, input bit en, input bit rdy);
    bit pr, push, pop;
    pr   = bp && (v >= 4'd1) && (v <= 4'd11);
    push = 1'b0;
    if (r) begin
      m_phase = P_IDLE; m_run = 0; m_held = 0; m_cand = 4'd0; m_ovf = 1'b0;
      m_q.delete();
      return;
    end
    pop = rdy && (m_q.size() > 0);
    if (!en) begin
      m_phase = P_IDLE; m_run = 0; m_held = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (pr) begin m_cand = v; m_run = 1; m_phase = P_DEB; end
        P_DEB: begin
          if (pr && v == m_cand) begin
            m_run++;
            if (m_run == DEB) begin push = 1'b1; m_phase = P_HELD; m_held = 0; end
          end else begin
            m_phase = P_IDLE; m_run = 0;
          end
        end
        P_HELD: begin
          if (pr && v == m_cand) begin
            m_held++;
`ifdef KEY_REPEAT_EN
            if (m_held >= DELAY + 1 && (m_held - DELAY - 1) % PERIOD == 0) push = 1'b1;
`endif
          end else begin
            m_phase = P_REL;
            m_run = pr ? 0 : 1;
          end
        end
        default: begin
          m_run = pr ? 0 : m_run + 1;
          if (m_run >= DEB) m_phase = P_IDLE;
        end
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(m_cand);
    end
  endtask

  task automatic drive(input bit r, input bit bp, input logic [3:0] v, input bit en, input bit rdy);
    rst = r; button_pressed = bp; button_value = v; enable = en; evt_ready = rdy;
    @(posedge clk_1mhz);
    model_step(r, bp, v, en, rdy);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit         mv;
    logic [3:0] mc;
    mv = (m_q.size() > 0);
    mc = mv ? m_q[0] : 4'd0;
    chk({tag, ".valid"}, evt_valid, mv);
    chk({tag, ".code"}, evt_code, mc);
    chk({tag, ".ovf"}, evt_overflow, m_ovf);
    chk({tag, ".busy"}, busy, m_phase != P_IDLE);
  endtask

  task automatic press(input logic [3:0] code, input bit rdy);
    for (int i = 0; i < DEB; i++) drive(0, 1, code, 1, rdy);
    for (int i = 0; i < DEB; i++) drive(0, 0, 4'd0, 1, rdy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, evt_valid, 0);
    chk({tag, ".code"}, evt_code, 0);
    chk({tag, ".ovf"}, evt_overflow, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  typedef struct {
    bit bp; logic [3:0] v; bit en; bit rdy;
    bit ev; logic [3:0] ec; bit eb;
  } vec_t;

  vec_t tbl[11];
  int   n_evt;
  int   exp_evt;

  initial begin
    // single debounced press of 5, then released; then a short bounce of 3
    tbl[0]  = '{1, 4'd5, 1, 1, 0, 4'd0, 1};
    tbl[1]  = '{1, 4'd5, 1, 1, 0, 4'd0, 1};
    tbl[2]  = '{1, 4'd5, 1, 1, 0, 4'd0, 1};
    tbl[3]  = '{1, 4'd5, 1, 1, 1, 4'd5, 1};
    tbl[4]  = '{0, 4'd0, 1, 1, 0, 4'd0, 1};
    tbl[5]  = '{0, 4'd0, 1, 1, 0, 4'd0, 1};
    tbl[6]  = '{0, 4'd0, 1, 1, 0, 4'd0, 1};
    tbl[7]  = '{0, 4'd0, 1, 1, 0, 4'd0, 0};
    tbl[8]  = '{1, 4'd3, 1, 1, 0, 4'd0, 1};
    tbl[9]  = '{1, 4'd3, 1, 1, 0, 4'd0, 1};
    tbl[10] = '{0, 4'd0, 1, 1, 0, 4'd0, 0};

    drive(1, 0, 4'd0, 1, 0);
    chk_zero("reset");
    drive(0, 0, 4'd0, 1, 0);

    for (int i = 0; i < 11; i++) begin
      drive(0, tbl[i].bp, tbl[i].v, tbl[i].en, tbl[i].rdy);
      chk($sformatf("vec%0d.valid", i), evt_valid, tbl[i].ev);
      chk($sformatf("vec%0d.code", i), evt_code, tbl[i].ec);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].eb);
    end

    // Reset in the middle of a debounce
    drive(0, 1, 4'd7, 1, 1);
    drive(0, 1, 4'd7, 1, 1);
    drive(1, 1, 4'd7, 1, 1);
    chk_zero("rst_deb");
    n_evt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 4'd0, 1, 1);
      if (evt_valid) n_evt++;
    end
    chk("rst_deb.no_evt", n_evt, 0);

    // Enable low aborts a debounce
    drive(0, 1, 4'd2, 1, 1);
    drive(0, 1, 4'd2, 1, 1);
    drive(0, 1, 4'd2, 0, 1);
    chk("en_off.busy", busy, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 4'd2, 1, 1);
    chk("en_off.no_evt", evt_valid, 0);
    for (int i = 0; i < DEB; i++) drive(0, 0, 4'd0, 1, 1);

    // Overflow: five presses with no consumer
    drive(1, 0, 4'd0, 1, 0);
    for (int k = 1; k <= 5; k++) press(4'(k), 0);
    chk("ovf.flag", evt_overflow, 1);
    chk("ovf.valid", evt_valid, 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf.drain%0d", k), evt_code, k);
      drive(0, 0, 4'd0, 1, 1);
    end
    chk("ovf.empty", evt_valid, 0);
    chk("ovf.sticky", evt_overflow, 1);

    // Full queue with push and pop on the same edge
    drive(1, 0, 4'd0, 1, 0);
    for (int k = 1; k <= 4; k++) press(4'(k), 0);
    for (int i = 0; i < DEB - 1; i++) drive(0, 1, 4'd6, 1, 0);
    drive(0, 1, 4'd6, 1, 1);
    chk("fullpp.ovf", evt_overflow, 0);
    chk("fullpp.head", evt_code, 2);
    for (int i = 0; i < DEB; i++) drive(0, 0, 4'd0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fullpp.drain%0d", k), evt_code, (k == 3) ? 6 : k + 2);
      drive(0, 0, 4'd0, 1, 1);
    end
    chk("fullpp.empty", evt_valid, 0);

    // Reset with a non-empty queue
    press(4'd9, 0);
    chk("rst_q.valid_before", evt_valid, 1);
    drive(1, 0, 4'd0, 1, 0);
    chk_zero("rst_q");
    n_evt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'd0, 1, 1);
      if (evt_valid) n_evt++;
    end
    chk("rst_q.no_evt", n_evt, 0);

    // Long hold of code 11
`ifdef KEY_REPEAT_EN
    exp_evt = 3;
`else
    exp_evt = 1;
`endif
    n_evt = 0;
    for (int i = 0; i < DEB + DELAY + PERIOD + PERIOD; i++) begin
      drive(0, 1, 4'd11, 1, 1);
      if (evt_valid) begin
        n_evt++;
        chk("hold.code", evt_code, 11);
      end
    end
    for (int i = 0; i < DEB; i++) begin
      drive(0, 0, 4'd0, 1, 1);
      if (evt_valid) n_evt++;
    end
    chk("hold.events", n_evt, exp_evt);
    chk("hold.idle", busy, 0);

    // Random stimulus against the model
    drive(1, 0, 4'd0, 1, 0);
    check_model("rnd.rst");
    for (int n = 0; n < 250; n++) begin
      int         sel, len;
      bit         bp, en;
      logic [3:0] v;
      sel = $urandom_range(0, 6);
      bp  = (sel != 0);
      if (sel == 1) v = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(12, 15));
      else          v = 4'($urandom_range(1, 4));
      if (sel == 0) v = 4'($urandom_range(0, 15));
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 7);
      en  = ($urandom_range(0, 15) != 0);
      for (int c = 0; c < len; c++) begin
        drive(($urandom_range(0, 399) == 0), bp, v, en, ($urandom_range(0, 3) != 0));
        check_model("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
